// File: rtl/aud_dsp_pkg.sv
// Shared types and constants for the second-generation playback DSP.
package aud_dsp_pkg;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        FAST      = 2'd1,
        SLOW_HOLD = 2'd2,
        SLOW_LIN  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_READ,
        S_LATCH,
        S_CALC,
        S_OUT,
        S_PAUSE
    } state_e;

    // Playback controls captured when playback starts from idle
    typedef struct packed {
        mode_e mode;
        logic  rev;
        logic  loop;
    } ctrl_t;

    // Divider latency: one restoring step per dividend bit plus a sign-fix cycle
    function automatic int div_cyc(input int data_w, input int speed_w);
        return data_w + speed_w + 2;
    endfunction

endpackage

// File: rtl/aud_seq_div.sv
// Sequential restoring divider: signed dividend, positive divisor, quotient
// truncated toward zero. done is high exactly NUM_W+1 cycles after start.
module aud_seq_div #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_start,
    input  logic signed [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0]        i_den,
    output logic                    o_done,
    output logic signed [NUM_W-1:0] o_quot
);
    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] quo;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den;
    logic             neg;
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [DEN_W:0]   trial;

    assign trial  = {rem, quo[NUM_W-1]};
    assign o_done = run && (cnt == CNT_W'(NUM_W));
    assign o_quot = neg ? -$signed(quo) : $signed(quo);

    // Magnitude long division, one quotient bit per cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            quo <= '0;
            rem <= '0;
            den <= '0;
            neg <= 1'b0;
            run <= 1'b0;
            cnt <= '0;
        end else if (i_flush) begin
            run <= 1'b0;
        end else if (i_start) begin
            quo <= i_num[NUM_W-1] ? -i_num : i_num;
            rem <= '0;
            den <= i_den;
            neg <= i_num[NUM_W-1];
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            if (cnt == CNT_W'(NUM_W)) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (trial >= {1'b0, den}) begin
                    rem <= DEN_W'(trial - {1'b0, den});
                    quo <= {quo[NUM_W-2:0], 1'b1};
                end else begin
                    rem <= trial[DEN_W-1:0];
                    quo <= {quo[NUM_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/aud_dsp_gen2.sv
// Playback DSP: fetches SRAM samples on DAC LR-clock falling edges and emits
// normal / fast / slow-hold / slow-linear output, forward or reverse, with loop.
module aud_dsp_gen2
    import aud_dsp_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int SPEED_W = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_pause,
    input  logic                     i_stop,
    input  logic [1:0]               i_mode,
    input  logic [SPEED_W-1:0]       i_speed,
    input  logic                     i_reverse,
    input  logic                     i_loop,
    input  logic [ADDR_W-1:0]        i_end_addr,
    input  logic                     i_daclrck,
    input  logic signed [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0]        o_sram_addr,
    output logic signed [DATA_W-1:0] o_dac_data,
    output logic                     o_audplayer_en,
    output logic                     o_done,
    output logic                     o_busy
);
    localparam int PROD_W = div_cyc(DATA_W, SPEED_W) - 1;

    state_e                     st, nst;
    ctrl_t                      ctl;
    logic [SPEED_W-1:0]         speed_q, k;
    logic [ADDR_W-1:0]          pos, step, pos_nx;
    logic [ADDR_W:0]            fwd_sum;
    logic signed [DATA_W-1:0]   prev, cur, fetched, outv;
    logic signed [DATA_W-1:0]   lin_cur, lin_prev, base;
    logic signed [DATA_W:0]     diff;
    logic signed [PROD_W-1:0]   num, quot, sum;
    logic [SPEED_W:0]           n_fac;
    logic lr_q, ev, abort, out_fire, div_start, div_done;
    logic fresh, k_wrap, adv, over, fin, sum_unused;

    assign ev      = lr_q & ~i_daclrck;
    assign n_fac   = {1'b0, speed_q} + (SPEED_W+1)'(1);
    assign fresh   = (k == '0);
    assign k_wrap  = (k == speed_q);
    assign adv     = (ctl.mode == NORMAL) || (ctl.mode == FAST) || k_wrap;
    assign step    = (ctl.mode == FAST) ? ADDR_W'(n_fac) : ADDR_W'(1);
    assign fwd_sum = {1'b0, pos} + {1'b0, step};
    assign over    = ctl.rev ? (pos < step) : (fwd_sum > {1'b0, i_end_addr});
    assign pos_nx  = over ? (ctl.rev ? i_end_addr : '0)
                          : (ctl.rev ? pos - step : fwd_sum[ADDR_W-1:0]);
    assign fin     = adv && over && !ctl.loop;
    assign abort   = i_stop || (i_pause && st != S_IDLE);

    // Interpolation operands use the values that will be committed at OUT
    assign lin_cur  = fresh ? i_sram_data : cur;
    assign lin_prev = fresh ? cur : prev;
    assign diff     = {lin_cur[DATA_W-1], lin_cur} - {lin_prev[DATA_W-1], lin_prev};
    assign num      = {{SPEED_W{diff[DATA_W]}}, diff} * {{(DATA_W+1){1'b0}}, k};
    assign base     = fresh ? cur : prev;
    assign sum      = {{(PROD_W-DATA_W){base[DATA_W-1]}}, base} + quot;
    // |quot| < |diff|, so the result always sits between prev and cur
    assign sum_unused  = ^sum[PROD_W-1:DATA_W];
    assign o_sram_addr = pos;

    aud_seq_div #(.NUM_W(PROD_W), .DEN_W(SPEED_W+1)) u_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (abort),
        .i_start (div_start),
        .i_num   (num),
        .i_den   (n_fac),
        .o_done  (div_done),
        .o_quot  (quot)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) st <= S_IDLE;
        else       st <= nst;
    end

    // Next state: stop beats pause beats start
    always_comb begin
        nst = st;
        if (i_stop) begin
            nst = S_IDLE;
        end else if (i_pause) begin
            nst = (st == S_IDLE) ? S_IDLE : S_PAUSE;
        end else begin
            case (st)
                S_IDLE:  if (i_start) nst = S_PLAY;
                S_PAUSE: if (i_start) nst = S_PLAY;
                S_PLAY:  if (ev) nst = S_READ;
                S_READ:  nst = S_LATCH;
                S_LATCH: nst = (ctl.mode == SLOW_LIN) ? S_CALC : S_OUT;
                S_CALC:  if (div_done) nst = S_OUT;
                S_OUT:   nst = fin ? S_IDLE : S_PLAY;
                default: nst = S_IDLE;
            endcase
        end
    end

    // FSM-decoded strobes
    always_comb begin
        o_busy    = (st != S_IDLE);
        out_fire  = (st == S_OUT) && !abort;
        div_start = (st == S_LATCH) && (ctl.mode == SLOW_LIN) && !abort;
    end

    // LR clock history for falling-edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lr_q <= 1'b0;
        else       lr_q <= i_daclrck;
    end

    // Playback position, phase and sample history; committed only at OUT so
    // a pause discards the in-flight sample cleanly
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctl     <= '0;
            speed_q <= '0;
            pos     <= '0;
            k       <= '0;
            prev    <= '0;
            cur     <= '0;
            fetched <= '0;
            outv    <= '0;
        end else if (i_stop) begin
            pos  <= ctl.rev ? i_end_addr : '0;
            k    <= '0;
            prev <= '0;
            cur  <= '0;
        end else if (st == S_IDLE && nst == S_PLAY) begin
            ctl     <= '{mode: mode_e'(i_mode), rev: i_reverse, loop: i_loop};
            speed_q <= i_speed;
            pos     <= i_reverse ? i_end_addr : '0;
            k       <= '0;
            prev    <= '0;
            cur     <= '0;
        end else if (st == S_LATCH) begin
            fetched <= i_sram_data;
            outv    <= (ctl.mode == SLOW_HOLD && !fresh) ? cur : i_sram_data;
        end else if (st == S_CALC && div_done) begin
            outv <= sum[DATA_W-1:0];
        end else if (out_fire) begin
            if (ctl.mode == SLOW_HOLD || ctl.mode == SLOW_LIN) begin
                k <= k_wrap ? '0 : k + SPEED_W'(1);
                if (fresh) cur <= fetched;
                if (fresh && ctl.mode == SLOW_LIN) prev <= cur;
            end
            if (adv && !fin) pos <= pos_nx;
        end
    end

    // Output sample and strobes; output is silent outside active playback
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dac_data     <= '0;
            o_audplayer_en <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_audplayer_en <= out_fire;
            o_done         <= out_fire && fin;
            if (out_fire)                           o_dac_data <= outv;
            else if (nst == S_IDLE || nst == S_PAUSE) o_dac_data <= '0;
        end
    end

endmodule

// File: tb/tb_aud_dsp_gen2.sv
// Directed bench for aud_dsp_gen2 with a one-cycle-latency SRAM model.
module tb_aud_dsp_gen2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic [1:0]         mode = '0;
    logic [2:0]         speed = '0;
    logic               reverse = 1'b0, loop_en = 1'b0;
    logic [19:0]        end_addr = '0;
    logic               lrck = 1'b0;
    logic signed [15:0] sram_data;
    logic [19:0]        addr;
    logic signed [15:0] dac;
    logic               en, done, busy;

    logic signed [15:0] mem [16];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // SRAM: data for the presented address appears one cycle later
    always_ff @(posedge clk)
        sram_data <= (addr < 20'd16) ? mem[addr[3:0]] : 16'sd0;

    aud_dsp_gen2 dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_pause        (pause),
        .i_stop         (stop),
        .i_mode         (mode),
        .i_speed        (speed),
        .i_reverse      (reverse),
        .i_loop         (loop_en),
        .i_end_addr     (end_addr),
        .i_daclrck      (lrck),
        .i_sram_data    (sram_data),
        .o_sram_addr    (addr),
        .o_dac_data     (dac),
        .o_audplayer_en (en),
        .o_done         (done),
        .o_busy         (busy)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [1:0] m, input logic [2:0] s, input logic r,
                         input logic l, input logic [19:0] e);
        mode = m; speed = s; reverse = r; loop_en = l; end_addr = e;
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // One LR-clock falling edge, then wait (bounded) for the output strobe.
    // exp_lat counts negedges from the event cycle to the strobe; 0 skips it.
    task automatic play_one(input string tag, input logic signed [31:0] exp_d,
                            input int exp_lat, input logic exp_done);
        logic seen;
        int   lat;
        @(negedge clk) lrck = 1'b1;
        @(negedge clk) lrck = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            if (en) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        chk({tag, " strobe"}, seen, 1);
        if (seen) begin
            chk({tag, " data"}, dac, exp_d);
            chk({tag, " done"}, done, exp_done);
            if (exp_lat > 0) chk({tag, " latency"}, lat, exp_lat);
        end
    endtask

    initial begin
        logic signed [15:0] lin_exp [12];
        logic               seen;

        lin_exp = '{16'sd0, 16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd200,
                    16'sd0, -16'sd200, -16'sd400, -16'sd400, -16'sd401, -16'sd402};
        for (int a = 0; a < 16; a++) mem[a] = 16'(a);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst addr", addr, 0);
        chk("rst dac", dac, 0);
        chk("rst en", en, 0);
        chk("rst done", done, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Normal forward 0..9; a mid-play control change must be ignored
        setup(2'd0, 3'd0, 1'b0, 1'b0, 20'd9);
        pulse_start;
        chk("norm busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) setup(2'd1, 3'd3, 1'b1, 1'b1, 20'd9);
            play_one("norm", i, (i == 0) ? 4 : 0, i == 9);
        end
        @(negedge clk);
        chk("norm dac after done", dac, 0);
        chk("norm busy after done", busy, 0);

        // Fast reverse, N = 3
        setup(2'd1, 3'd2, 1'b1, 1'b0, 20'd9);
        pulse_start;
        chk("fast start addr", addr, 9);
        play_one("fast", 9, 0, 1'b0);
        play_one("fast", 6, 0, 1'b0);
        play_one("fast", 3, 0, 1'b0);
        play_one("fast", 0, 0, 1'b1);
        @(negedge clk);
        chk("fast busy after done", busy, 0);

        // Slow hold, N = 4, with pause and resume
        for (int a = 0; a < 16; a++) mem[a] = 16'(100 * a);
        setup(2'd2, 3'd3, 1'b0, 1'b0, 20'd15);
        pulse_start;
        for (int i = 0; i < 5; i++) play_one("hold", (i < 4) ? 0 : 100, (i == 0) ? 4 : 0, 1'b0);
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        chk("pause dac", dac, 0);
        chk("pause addr", addr, 1);
        chk("pause busy", busy, 1);
        @(negedge clk) lrck = 1'b1;
        @(negedge clk) lrck = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (en) seen = 1'b1;
        end
        chk("pause drops event", seen, 0);
        chk("pause addr frozen", addr, 1);
        pulse_start;
        play_one("hold resume", 100, 4, 1'b0);
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        chk("stop busy", busy, 0);
        chk("stop addr", addr, 0);

        // Slow linear, N = 4; third segment exercises truncation toward zero
        mem[0] = 16'sd400; mem[1] = -16'sd400; mem[2] = -16'sd403;
        setup(2'd3, 3'd3, 1'b0, 1'b0, 20'd15);
        pulse_start;
        for (int i = 0; i < 12; i++) play_one("lin", lin_exp[i], (i == 0) ? 25 : 0, 1'b0);
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;

        // Loop, end address 3; then stop and pause together
        for (int a = 0; a < 16; a++) mem[a] = 16'(a);
        setup(2'd0, 3'd0, 1'b0, 1'b1, 20'd3);
        pulse_start;
        for (int i = 0; i < 6; i++) begin
            play_one("loop", i % 4, 0, 1'b0);
            chk("loop next addr", addr, (i + 1) % 4);
        end
        @(negedge clk) begin stop = 1'b1; pause = 1'b1; end
        @(negedge clk) begin stop = 1'b0; pause = 1'b0; end
        chk("stop+pause busy", busy, 0);
        chk("stop+pause addr", addr, 0);

        // Asynchronous reset while the divider is running
        mem[0] = 16'sd400; mem[1] = -16'sd400;
        setup(2'd3, 3'd3, 1'b0, 1'b0, 20'd15);
        pulse_start;
        for (int i = 0; i < 5; i++) play_one("pre-rst", lin_exp[i], 0, 1'b0);
        @(negedge clk) lrck = 1'b1;
        @(negedge clk) lrck = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst addr", addr, 0);
        chk("async rst dac", dac, 0);
        chk("async rst busy", busy, 0);
        chk("async rst en", en, 0);
        chk("async rst done", done, 0);
        @(negedge clk) rst = 1'b0;
        pulse_start;
        play_one("post-rst", 0, 25, 1'b0);
        play_one("post-rst", 100, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
